servo_ramp: RTL and testbench

Slew-rate-limited position generator that drives the `pulse_len` input of the servo PWM stage. It accepts target pulse widths (µs) over a valid/ready handshake and clamps them to a safe range. It then moves its `pulse_len` output toward the target by at most `STEP_US` per servo frame, so the servo never sees a step jump. It keeps its own frame timebase with the same period as the PWM stage, so `pulse_len` changes at most once per 20 ms frame.

---
 rtl/servo_ramp.sv | 140 ++++++++++++++
 tb/tb_servo_ramp.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/servo_ramp.sv
// Slew-rate-limited servo position generator: clamps commanded pulse widths and
// ramps pulse_len toward the target by at most STEP_US once per PWM frame.
module servo_ramp #(
   parameter int unsigned CLK_F     = 50,
   parameter int unsigned FRAME_US  = 20000,
   parameter int unsigned MIN_US    = 1000,
   parameter int unsigned MAX_US    = 2000,
   parameter int unsigned CENTER_US = 1500,
   parameter int unsigned STEP_US   = 10
) (
   input  logic        CLK,
   input  logic        RESETN,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [15:0] cmd_target,
   output logic [15:0] pulse_len,
   output logic        busy,
   output logic        done,
   output logic        frame_tick
);

   localparam int unsigned PW    = 16;
   localparam int unsigned PRE_W = (CLK_F > 1) ? $clog2(CLK_F) : 1;
   localparam int unsigned US_W  = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_F - 1);
   localparam logic [US_W-1:0]  US_LAST  = US_W'(FRAME_US - 1);
   localparam logic [PW-1:0]    MIN_V    = PW'(MIN_US);
   localparam logic [PW-1:0]    MAX_V    = PW'(MAX_US);
   localparam logic [PW-1:0]    CENTER_V = PW'(CENTER_US);
   localparam logic [PW-1:0]    STEP_V   = PW'(STEP_US);
   localparam logic [PW:0]      STEP_X   = (PW+1)'(STEP_US);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RAMP = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [PRE_W-1:0]  prescaler_q, prescaler_d;
   logic [US_W-1:0]   us_cnt_q, us_cnt_d;
   logic              frame_tick_q, frame_tick_d;
   logic [PW-1:0]     pulse_len_q, pulse_len_d;
   logic [PW-1:0]     target_q, target_d;
   logic              done_q, done_d;

   logic              us_tick_c;
   logic              up_c;
   logic [PW:0]       dist_c;
   logic [PW-1:0]     clamp_c;

   // State and datapath registers
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q      <= S_IDLE;
         prescaler_q  <= '0;
         us_cnt_q     <= '0;
         frame_tick_q <= 1'b0;
         pulse_len_q  <= CENTER_V;
         target_q     <= CENTER_V;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         prescaler_q  <= prescaler_d;
         us_cnt_q     <= us_cnt_d;
         frame_tick_q <= frame_tick_d;
         pulse_len_q  <= pulse_len_d;
         target_q     <= target_d;
         done_q       <= done_d;
      end
   end

   // Free-running frame timebase; never resynchronised by commands
   always_comb begin
      prescaler_d  = prescaler_q;
      us_cnt_d     = us_cnt_q;
      frame_tick_d = 1'b0;
      us_tick_c    = (prescaler_q == PRE_LAST);
      if (us_tick_c) begin
         prescaler_d = '0;
         if (us_cnt_q == US_LAST) begin
            us_cnt_d     = '0;
            frame_tick_d = 1'b1;
         end else begin
            us_cnt_d = us_cnt_q + US_W'(1);
         end
      end else begin
         prescaler_d = prescaler_q + PRE_W'(1);
      end
   end

   // Command accept and per-frame ramp; the last step snaps to target so no overshoot
   always_comb begin
      state_d     = state_q;
      target_d    = target_q;
      pulse_len_d = pulse_len_q;
      done_d      = 1'b0;

      if (cmd_target < MIN_V) begin
         clamp_c = MIN_V;
      end else if (cmd_target > MAX_V) begin
         clamp_c = MAX_V;
      end else begin
         clamp_c = cmd_target;
      end

      up_c   = (target_q >= pulse_len_q);
      dist_c = up_c ? ({1'b0, target_q} - {1'b0, pulse_len_q})
                    : ({1'b0, pulse_len_q} - {1'b0, target_q});

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               target_d = clamp_c;
               state_d  = S_RAMP;
            end
         end
         S_RAMP: begin
            if (frame_tick_q) begin
               if (dist_c <= STEP_X) begin
                  pulse_len_d = target_q;
                  done_d      = 1'b1;
                  state_d     = S_IDLE;
               end else if (up_c) begin
                  pulse_len_d = pulse_len_q + STEP_V;
               end else begin
                  pulse_len_d = pulse_len_q - STEP_V;
               end
            end
         end
      endcase
   end

   assign cmd_ready  = (state_q == S_IDLE);
   assign busy       = (state_q == S_RAMP);
   assign pulse_len  = pulse_len_q;
   assign done       = done_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_servo_ramp.sv
// Directed bench for servo_ramp with a 20-cycle frame (CLK_F=2, FRAME_US=10)
// and STEP_US=100; expected pulse widths are hand-computed.
module tb_servo_ramp;

   logic        clk = 1'b0;
   logic        rstn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_target;
   logic [15:0] pulse_len;
   logic        busy;
   logic        done;
   logic        frame_tick;

   int n_cmp = 0;
   int n_err = 0;
   int range_err = 0;
   int chg_err = 0;
   logic [15:0] prev_pl = 16'd1500;
   logic        prev_ft = 1'b0;
   logic        prev_rstn = 1'b0;

   servo_ramp #(
      .CLK_F    (2),
      .FRAME_US (10),
      .STEP_US  (100)
   ) dut (
      .CLK        (clk),
      .RESETN     (rstn),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_target (cmd_target),
      .pulse_len  (pulse_len),
      .busy       (busy),
      .done       (done),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Range and "changes only after a frame_tick" watch, outside reset
   always @(negedge clk) begin
      if (rstn && prev_rstn) begin
         if (pulse_len < 16'd1000 || pulse_len > 16'd2000) range_err <= range_err + 1;
         if (pulse_len != prev_pl && !prev_ft) chg_err <= chg_err + 1;
      end
      prev_pl   <= pulse_len;
      prev_ft   <= frame_tick;
      prev_rstn <= rstn;
   end

   task automatic run_idle(input int n, output int first, output int cnt, output bit dn);
      first = 0;
      cnt   = 0;
      dn    = 1'b0;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         if (frame_tick) begin
            if (first == 0) first = i;
            cnt++;
         end
         if (done) dn = 1'b1;
      end
   endtask

   task automatic send_cmd(input logic [15:0] t);
      cmd_valid  = 1'b1;
      cmd_target = t;
      for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge clk);
      if (!cmd_ready) check("accept_timeout", 32'(0), 32'(1));
      @(negedge clk);
      cmd_valid = 1'b0;
      check("acc_busy", 32'(busy), 32'(1));
      check("acc_ready", 32'(cmd_ready), 32'(0));
   endtask

   task automatic ramp_step(input logic [15:0] exp, input bit last);
      bit early = 1'b0;
      for (int i = 0; i < 60 && !frame_tick; i++) begin
         if (done || cmd_ready) early = 1'b1;
         @(negedge clk);
      end
      if (!frame_tick) check("tick_timeout", 32'(0), 32'(1));
      check("hold_between_ticks", 32'(early), 32'(0));
      @(negedge clk);
      check("step_pulse_len", 32'(pulse_len), 32'(exp));
      check("step_done", 32'(done), 32'(last));
      check("step_busy", 32'(busy), 32'(!last));
      check("step_ready", 32'(cmd_ready), 32'(last));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  first, cnt;
      bit  dn;
      rstn       = 1'b1;
      cmd_valid  = 1'b0;
      cmd_target = 16'd0;
      #2 rstn = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_pulse_len", 32'(pulse_len), 32'(1500));
      check("rst_ready", 32'(cmd_ready), 32'(1));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_frame_tick", 32'(frame_tick), 32'(0));
      #1 rstn = 1'b1;

      // Idle after reset: ticks at 20, 40, ... 100
      run_idle(100, first, cnt, dn);
      check("idle_first_tick", 32'(first), 32'(20));
      check("idle_tick_count", 32'(cnt), 32'(5));
      check("idle_done_seen", 32'(dn), 32'(0));
      check("idle_pulse_len", 32'(pulse_len), 32'(1500));
      check("idle_ready", 32'(cmd_ready), 32'(1));
      check("idle_busy", 32'(busy), 32'(0));

      // Up ramp
      send_cmd(16'd2000);
      ramp_step(16'd1600, 1'b0);
      ramp_step(16'd1700, 1'b0);
      ramp_step(16'd1800, 1'b0);
      ramp_step(16'd1900, 1'b0);
      ramp_step(16'd2000, 1'b1);

      // Clamp high (equal to current, completes in one frame), clamp low
      send_cmd(16'd2500);
      ramp_step(16'd2000, 1'b1);
      send_cmd(16'd0);
      for (int k = 1; k <= 9; k++) ramp_step(16'(2000 - 100 * k), 1'b0);
      ramp_step(16'd1000, 1'b1);

      // Back to centre, then non-multiple distances
      send_cmd(16'd1500);
      for (int k = 1; k <= 4; k++) ramp_step(16'(1000 + 100 * k), 1'b0);
      ramp_step(16'd1500, 1'b1);
      send_cmd(16'd1550);
      ramp_step(16'd1550, 1'b1);
      send_cmd(16'd1390);
      ramp_step(16'd1450, 1'b0);
      ramp_step(16'd1390, 1'b1);

      // Command held during ramp is only taken on the done cycle
      send_cmd(16'd1700);
      ramp_step(16'd1490, 1'b0);
      cmd_valid  = 1'b1;
      cmd_target = 16'd1800;
      ramp_step(16'd1590, 1'b0);
      ramp_step(16'd1690, 1'b0);
      ramp_step(16'd1700, 1'b1);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("held_acc_busy", 32'(busy), 32'(1));
      check("held_acc_pulse", 32'(pulse_len), 32'(1700));
      ramp_step(16'd1800, 1'b1);

      // Accept on the same edge that ends a frame_tick cycle: no step on that tick
      for (int i = 0; i < 60 && !frame_tick; i++) @(negedge clk);
      check("coinc_tick_seen", 32'(frame_tick), 32'(1));
      cmd_valid  = 1'b1;
      cmd_target = 16'd1600;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("coinc_busy", 32'(busy), 32'(1));
      check("coinc_no_step", 32'(pulse_len), 32'(1800));
      ramp_step(16'd1700, 1'b0);
      ramp_step(16'd1600, 1'b1);

      // Reset in the middle of a ramp
      send_cmd(16'd2000);
      ramp_step(16'd1700, 1'b0);
      #2 rstn = 1'b0;
      #1;
      check("mrst_pulse_len", 32'(pulse_len), 32'(1500));
      check("mrst_busy", 32'(busy), 32'(0));
      check("mrst_ready", 32'(cmd_ready), 32'(1));
      check("mrst_done", 32'(done), 32'(0));
      repeat (2) @(negedge clk);
      #1 rstn = 1'b1;
      run_idle(40, first, cnt, dn);
      check("mrst_first_tick", 32'(first), 32'(20));
      check("mrst_tick_count", 32'(cnt), 32'(2));
      check("mrst_done_seen", 32'(dn), 32'(0));
      check("mrst_pulse_after", 32'(pulse_len), 32'(1500));

      @(negedge clk);
      check("range_violations", 32'(range_err), 32'(0));
      check("change_without_tick", 32'(chg_err), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
